regfile_dump: RTL and testbench

Debug/maintenance sequencer that drives the register-file ports from the opposite side to the datapath. On command it either clears every register by driving the write port, or walks the read port and streams each register's address and contents out over a valid/ready interface. It sits beside the register file, sharing its port signals through a debug mux; the core is halted while the block is busy.

---
 rtl/regfile_dump.sv | 119 +++++++++++
 tb/tb_regfile_dump.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Debug sequencer for the register file: clears every register through the write port,
// or dumps each register over a valid/ready stream, on a one-cycle start command.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_READ   = 3'd2,
    S_SEND   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              last_s;

  assign last_s = (idx_q == LAST_IDX);

  // State, index and captured beat registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state and index sequencing; the beat is captured in READ and held through SEND
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = mode_i ? S_CLEAR : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (last_s) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        out_addr_d = idx_q;
        out_data_d = rf_rdata_i;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (out_ready_i) begin
          if (last_s) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state, so reset clears them immediately
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_FINISH);
    rf_we_o     = (state_q == S_CLEAR);
    out_valid_o = (state_q == S_SEND);
    rf_raddr_o  = idx_q;
    rf_waddr_o  = idx_q;
    rf_wdata_o  = '0;
    out_addr_o  = out_addr_q;
    out_data_o  = out_data_q;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file and a per-cycle monitor.
module tb_regfile_dump;

  logic        clk, rst, start, mode, busy, done, rf_we, out_valid, out_ready;
  logic [5:0]  rf_raddr, rf_waddr, out_addr;
  logic [31:0] rf_rdata, rf_wdata, out_data;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic        tb_we;
  logic [4:0]  tb_wa;
  logic [31:0] tb_wd;

  int errors = 0, checks = 0;
  int cnt = 0, start_t, done_t, first_beat_t, first_wr_t;
  int nbeats, nwrites, ndone, wdata_bad, hold_bad, stall_seen;
  logic [5:0]  baddr [64];
  logic [31:0] bdata [64];
  logic [5:0]  wlog [64];
  logic        pv, pr;
  logic [5:0]  pa;
  logic [31:0] pd;

  regfile_dump #(.NUM_REGS(32), .ADDR_W(6), .DATA_W(32)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done),
    .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_data_o(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (tb_we) rf[tb_wa] <= tb_wd;
    else if (rf_we) rf[rf_waddr[4:0]] <= rf_wdata;
  end
  assign rf_rdata = rf[rf_raddr[4:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples the cycle about to be clocked: inputs and outputs are stable here.
  task automatic mon();
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (nbeats == 0) first_beat_t = cnt;
        if (nbeats < 64) begin baddr[nbeats] = out_addr; bdata[nbeats] = out_data; end
        nbeats++;
      end
      if (rf_we) begin
        if (nwrites == 0) first_wr_t = cnt;
        if (nwrites < 64) wlog[nwrites] = rf_waddr;
        if (rf_wdata !== 32'h0) wdata_bad++;
        nwrites++;
      end
      if (done) begin ndone++; done_t = cnt; end
      if (out_valid && !out_ready) stall_seen++;
      if (pv && !pr && (!out_valid || out_addr !== pa || out_data !== pd)) hold_bad++;
      pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
    end else begin
      pv = 1'b0;
    end
    cnt++;
  endtask

  task automatic cyc();
    mon();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    tb_we = 1'b1; tb_wa = a[4:0]; tb_wd = d;
    exp_rf[a] = d;
    @(negedge clk);
    #1;
    tb_we = 1'b0;
  endtask

  task automatic clr_mon();
    nbeats = 0; nwrites = 0; ndone = 0; wdata_bad = 0; hold_bad = 0; stall_seen = 0;
    first_beat_t = -1; first_wr_t = -1; done_t = -1; pv = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input int stall_addr, input int stall_n, input int pulse_at);
    int stalled = 0;
    clr_mon();
    start = 1'b1; mode = m; out_ready = 1'b1; start_t = cnt;
    cyc();
    start = 1'b0; mode = 1'b0;
    for (int i = 1; i < 400 && ndone == 0; i++) begin
      if (out_valid && int'(out_addr) == stall_addr && stalled < stall_n) begin
        out_ready = 1'b0; stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (i == pulse_at) begin start = 1'b1; mode = 1'b1; end
      else begin start = 1'b0; mode = 1'b0; end
      cyc();
    end
    start = 1'b0; out_ready = 1'b1;
    chk("cmd_completed", (ndone != 0), 1'b1);
  endtask

  task automatic check_dump(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (baddr[i] !== 6'(i) || bdata[i] !== exp_rf[i]) bad++;
    chk({tag, "_nbeats"}, nbeats, 32);
    chk({tag, "_beats_bad"}, bad, 0);
    chk({tag, "_no_writes"}, nwrites, 0);
  endtask

  initial begin
    tb_we = 1'b0; tb_wa = 5'd0; tb_wd = 32'h0;
    rst = 1'b0;
    start = 1'($urandom); mode = 1'($urandom); out_ready = 1'($urandom);
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_raddr", rf_raddr, 6'd0);
    chk("rst_waddr", rf_waddr, 6'd0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_oaddr", out_addr, 6'd0);
    chk("rst_odata", out_data, 32'h0);
    @(negedge clk);
    #1;
    start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) wr(i, 32'hC0DE_0000 | 32'(i));
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_we", rf_we, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_odata", out_data, 32'h0);

    // Preload and dump
    wr(3, 32'hABCD_EFFF);
    wr(5, 32'hFBCD_E111);
    run_cmd(1'b0, -1, 0, 0);
    check_dump("dump1");
    chk("dump1_beat3", bdata[3], 32'hABCD_EFFF);
    chk("dump1_beat5", bdata[5], 32'hFBCD_E111);
    chk("dump1_first_beat", first_beat_t - start_t, 2);
    chk("dump1_done_lat", done_t - start_t, 65);
    chk("dump1_ndone", ndone, 1);

    // Clear, then an immediate back-to-back dump
    run_cmd(1'b1, -1, 0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 32; i++) if (wlog[i] !== 6'(i)) bad++;
      chk("clr_nwrites", nwrites, 32);
      chk("clr_waddr_bad", bad, 0);
      chk("clr_wdata_bad", wdata_bad, 0);
      chk("clr_first_we", first_wr_t - start_t, 1);
      chk("clr_done_lat", done_t - start_t, 33);
      chk("clr_nbeats", nbeats, 0);
    end
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    run_cmd(1'b0, -1, 0, 0);
    check_dump("dump0");
    chk("dump0_done_lat", done_t - start_t, 65);

    // Backpressure at beat 7
    for (int i = 0; i < 32; i++) wr(i, 32'h5A00_0000 | (32'(i) << 8) | 32'(i));
    run_cmd(1'b0, 7, 5, 0);
    check_dump("bp");
    chk("bp_stall_cycles", stall_seen, 5);
    chk("bp_hold_bad", hold_bad, 0);
    chk("bp_beat7", bdata[7], 32'h5A00_0707);
    chk("bp_done_lat", done_t - start_t, 70);

    // Start pulse while busy is ignored
    run_cmd(1'b0, -1, 0, 10);
    check_dump("busy_start");
    chk("busy_start_done_lat", done_t - start_t, 65);
    for (int i = 0; i < 4; i++) cyc();
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_idle", busy, 1'b0);
    chk("busy_start_nwrites", nwrites, 0);

    // Reset during SEND of beat 10
    clr_mon();
    start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100 && !(out_valid && out_addr == 6'd10); i++) cyc();
    chk("rstmid_reached", (out_valid && out_addr == 6'd10), 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_oaddr", out_addr, 6'd0);
    chk("rstmid_nbeats", nbeats, 10);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rstmid_no_resume", busy, 1'b0);
    run_cmd(1'b0, -1, 0, 0);
    check_dump("after_rst");
    chk("after_rst_first_addr", baddr[0], 6'd0);
    chk("after_rst_done_lat", done_t - start_t, 65);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
